// File: rtl/oam_dma_if.sv
// CPU-side and mem_map-side signals of the OAM DMA engine.
// The slave modport is the DMA engine; the master modport is whatever surrounds it.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic [15:0] addr_bus;
    logic [7:0]  mem_in;
    logic [7:0]  mem_out;
    logic        mem_write;
    logic        dma_active;

    modport master (
        output cpu_addr, cpu_wdata, cpu_write, mem_in,
        input  cpu_rdata, addr_bus, mem_out, mem_write, dma_active
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write, mem_in,
        output cpu_rdata, addr_bus, mem_out, mem_write, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src_hi,idx} to OAM_BASE+idx, one byte per M-cycle.
// Define OAM_DMA_BUS_CONFLICT_EN to make blocked CPU reads return the last DMA-latched byte instead of 8'hFF.
module oam_dma #(
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     mclk_in,
    oam_dma_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DELAY, RD, WR, WAIT} state_t;

    localparam logic [7:0]  LEN8    = 8'(DMA_LEN);
    localparam logic [15:0] HRAM_LO = 16'hFF80;
    localparam logic [15:0] HRAM_HI = 16'hFFFE;

    state_t     state_reg, state_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] src_hi_reg, src_hi_next;
    logic [7:0] latch_reg, latch_next;

    logic       start;
    logic       is_reg;
    logic       in_hram;
    logic       dma_active;
    logic       blocked;
    logic [7:0] src_masked;
    logic [7:0] blocked_data;

    assign is_reg  = (bus.cpu_addr == DMA_REG_ADDR);
    assign in_hram = (bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI);
    assign start   = bus.cpu_write && mclk_in && is_reg;

    // The trailing WAIT after the last byte only waits for the M-cycle boundary; the bus is already free.
    assign dma_active = (state_reg != IDLE) && !((state_reg == WAIT) && (idx_reg == LEN8));
    assign blocked    = dma_active && !in_hram && !is_reg;
    assign bus.dma_active = dma_active;

    // Echo-RAM pages E0-FF alias onto C0-DF for the source fetch only.
    assign src_masked = (src_hi_reg[7:5] == 3'b111) ? {src_hi_reg[7:6], 1'b0, src_hi_reg[4:0]}
                                                    : src_hi_reg;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign blocked_data = latch_reg;
`else
    assign blocked_data = 8'hFF;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            idx_reg    <= 8'h00;
            src_hi_reg <= 8'h00;
            latch_reg  <= 8'h00;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            src_hi_reg <= src_hi_next;
            latch_reg  <= latch_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        src_hi_next = src_hi_reg;
        latch_next  = latch_reg;
        case (state_reg)
            IDLE:  state_next = IDLE;
            DELAY: if (mclk_in) state_next = WAIT;
            RD: begin
                latch_next = bus.mem_in;
                state_next = WR;
            end
            WR: begin
                idx_next   = idx_reg + 8'd1;
                state_next = WAIT;
            end
            WAIT: begin
                if (mclk_in) begin
                    if (idx_reg == LEN8) begin
                        state_next = IDLE;
                        idx_next   = 8'h00;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 8'h00;
            end
        endcase
        // A start write wins over whatever the engine was doing, including a running transfer.
        if (start) begin
            src_hi_next = bus.cpu_wdata;
            idx_next    = 8'h00;
            state_next  = DELAY;
        end
    end

    always_comb begin
        bus.addr_bus  = bus.cpu_addr;
        bus.mem_out   = bus.cpu_wdata;
        bus.mem_write = bus.cpu_write && mclk_in && !blocked && !is_reg && !rst_in;
        bus.cpu_rdata = is_reg ? src_hi_reg : (blocked ? blocked_data : bus.mem_in);
        case (state_reg)
            RD: begin
                bus.addr_bus  = {src_masked, idx_reg};
                bus.mem_write = 1'b0;
                bus.cpu_rdata = is_reg ? src_hi_reg : blocked_data;
            end
            WR: begin
                bus.addr_bus  = OAM_BASE + {8'h00, idx_reg};
                bus.mem_out   = latch_reg;
                bus.mem_write = !rst_in;
                bus.cpu_rdata = is_reg ? src_hi_reg : blocked_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: CPU op table, directed transfers, restarts, resets and random sources.
module tb_oam_dma;
    localparam int LEN = 160;
    localparam int NV  = 14;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [1:0]  kind;     // 0: exp_rd as given, 1: blocked-read value
        logic [7:0]  exp_rd;
        logic        exp_mw;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic mclk_in;
    oam_dma_if bus();

    logic [7:0] mem [0:65535];
    assign bus.mem_in = mem[bus.addr_bus];

    oam_dma #(.DMA_LEN(LEN), .OAM_BASE(16'hFE00), .DMA_REG_ADDR(16'hFF46)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .mclk_in(mclk_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int phase = 3;
    int wr_all = 0;
    int wr_oam = 0;
    int act_pulses = 0;
    int act_first = -1;
    int act_last = -1;
    int wq[$];
    logic [7:0] exp_img [0:LEN-1];
    vec_t vt [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe the finishing cycle at negedge (memory model + monitors), then advance.
    task automatic step();
        @(negedge clk_in);
        if (bus.mem_write) begin
            mem[bus.addr_bus] = bus.mem_out;
            wr_all++;
            if (int'(bus.addr_bus) >= 'hFE00 && int'(bus.addr_bus) < 'hFE00 + LEN) begin
                wr_oam++;
                wq.push_back(cyc);
            end
        end
        if (bus.dma_active) begin
            if (mclk_in) act_pulses++;
            if (act_first < 0) act_first = cyc;
            act_last = cyc;
        end
        @(posedge clk_in);
        #1;
        cyc++;
        phase = (phase + 1) % 4;
        mclk_in = (phase == 0);
    endtask

    task automatic cpu_op(input string tag, input logic wr, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic mw, output int c);
        do step(); while (!mclk_in);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_write = wr;
        #2;
        rd = bus.cpu_rdata;
        mw = bus.mem_write;
        c  = cyc;
        $display("op cyc=%0d %s %s addr=%h wdata=%h rdata=%h mem_write=%0d active=%0d",
                 c, tag, wr ? "W" : "R", a, d, rd, mw, bus.dma_active);
        step();
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
    endtask

    // Source page as the copy rules define it: E0-FF alias 32 pages lower.
    function automatic int src_base(input logic [7:0] v);
        int h;
        h = int'(v);
        if (h >= 'hE0) h = h - 'h20;
        return h * 256;
    endfunction

    task automatic fill_src(input logic [7:0] v, input bit ramp);
        int b;
        b = src_base(v);
        if (v >= 8'hE0)
            for (int i = 0; i < LEN; i++) mem[int'(v) * 256 + i] = 8'($urandom);
        for (int i = 0; i < LEN; i++) mem[b + i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while (wr_oam < target && n < 2000) begin
            step();
            n++;
        end
        chk("wait_for_writes", int'(wr_oam >= target), 1);
    endtask

    task automatic wait_idle(input int from_c);
        int n;
        n = 0;
        while ((bus.dma_active || cyc <= from_c + 1) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_for_idle", int'(bus.dma_active), 0);
    endtask

    task automatic run_table(input int base);
        logic [7:0] rd;
        logic [7:0] exp_rd;
        logic       mw;
        int         c;
        int         w;
        for (int t = 0; t < NV; t++) begin
            cpu_op($sformatf("tbl%0d", t), vt[t].wr, vt[t].addr, vt[t].wdata, rd, mw, c);
            w = wr_oam - base;
            exp_rd = vt[t].exp_rd;
            if (vt[t].kind == 2'd1) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
                exp_rd = (w > 0) ? exp_img[w - 1] : 8'h00;
`else
                exp_rd = 8'hFF;
`endif
            end
            if (!vt[t].wr) chk($sformatf("tbl%0d_rdata", t), rd, exp_rd);
            chk($sformatf("tbl%0d_mem_write", t), mw, vt[t].exp_mw);
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] s1, input int k, input logic [7:0] s2,
                        input bit ramp, input bit table_en);
        logic [7:0] fin;
        logic [7:0] rd;
        logic       mw;
        int c0, c1, c, base, base_all, exp_n, first, last, bad;
        fin = (k >= 0) ? s2 : s1;
        fill_src(s1, ramp);
        if (k >= 0) fill_src(s2, 1'b0);
        for (int i = 0; i < LEN; i++) begin
            exp_img[i] = mem[src_base(fin) + i];
            mem['hFE00 + i] = ~exp_img[i];
        end
        base = wr_oam;
        base_all = wr_all;
        wq.delete();
        act_pulses = 0;
        act_first = -1;
        act_last = -1;
        cpu_op({tag, "_start"}, 1'b1, 16'hFF46, s1, rd, mw, c0);
        chk({tag, "_start_not_forwarded"}, mw, 0);
        c1 = c0;
        if (table_en) begin
            wait_wr(base + 5);
            run_table(base);
        end
        if (k >= 0) begin
            wait_wr(base + k);
            cpu_op({tag, "_restart"}, 1'b1, 16'hFF46, s2, rd, mw, c1);
            chk({tag, "_restart_not_forwarded"}, mw, 0);
            chk({tag, "_writes_before_restart"}, wr_oam - base, k);
        end
        wait_idle(c1);
        repeat (8) step();
        exp_n = (k >= 0) ? k + LEN : LEN;
        chk({tag, "_oam_write_count"}, wr_oam - base, exp_n);
        if (!table_en) chk({tag, "_total_write_count"}, wr_all - base_all, exp_n);
        first = -1;
        foreach (wq[j]) if (first < 0 && wq[j] > c1) first = wq[j];
        last = (wq.size() > 0) ? wq[wq.size() - 1] : -1;
        chk({tag, "_first_byte_cycle"}, first - c1, 10);
        chk({tag, "_last_byte_cycle"}, last - c1, 10 + 4 * (LEN - 1));
        if (k < 0) begin
            chk({tag, "_active_first_cycle"}, act_first - c0, 1);
            chk({tag, "_active_last_cycle"}, act_last - c0, 10 + 4 * (LEN - 1));
            chk({tag, "_active_mcycles"}, act_pulses, LEN + 1);
        end
        bad = 0;
        for (int i = 0; i < LEN; i++) if (mem['hFE00 + i] != exp_img[i]) bad++;
        chk({tag, "_oam_bad_bytes"}, bad, 0);
        cpu_op({tag, "_readback"}, 1'b0, 16'hFF46, 8'h00, rd, mw, c);
        chk({tag, "_reg_readback"}, rd, fin);
        $display("xfer %s src=%h restart_at=%0d src2=%h writes=%0d", tag, s1, k, s2, wr_oam - base);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] s1;
        logic       mw;
        int c, base, k;

        vt[0]  = '{1'b1, 16'hFF90, 8'h55, 2'd0, 8'h00, 1'b1};
        vt[1]  = '{1'b0, 16'hFF90, 8'h00, 2'd0, 8'h55, 1'b0};
        vt[2]  = '{1'b1, 16'hC000, 8'hAA, 2'd0, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 16'h8000, 8'h00, 2'd1, 8'h00, 1'b0};
        vt[4]  = '{1'b0, 16'hC000, 8'h00, 2'd1, 8'h00, 1'b0};
        vt[5]  = '{1'b0, 16'hFF46, 8'h00, 2'd0, 8'hC1, 1'b0};
        vt[6]  = '{1'b1, 16'hFFFE, 8'h12, 2'd0, 8'h00, 1'b1};
        vt[7]  = '{1'b0, 16'hFFFE, 8'h00, 2'd0, 8'h12, 1'b0};
        vt[8]  = '{1'b1, 16'hFF80, 8'h9A, 2'd0, 8'h00, 1'b1};
        vt[9]  = '{1'b0, 16'hFF80, 8'h00, 2'd0, 8'h9A, 1'b0};
        vt[10] = '{1'b1, 16'hFF7F, 8'h34, 2'd0, 8'h00, 1'b0};
        vt[11] = '{1'b1, 16'hFFFF, 8'h77, 2'd0, 8'h00, 1'b0};
        vt[12] = '{0, 16'hFF7F, 8'h00, 2'd1, 8'h00, 1'b0};
        vt[13] = '{0, 16'hFE05, 8'h00, 2'd1, 8'h00, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem['h8000] = 8'h5A;
        mem['hFF7F] = 8'h6B;

        rst_in = 1'b1;
        mclk_in = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_wdata = 8'h00;
        bus.cpu_write = 1'b0;
        repeat (3) step();

        // Reset state and write suppression while reset is held.
        do step(); while (!mclk_in);
        bus.cpu_addr = 16'hC000;
        bus.cpu_wdata = 8'h99;
        bus.cpu_write = 1'b1;
        #2;
        chk("reset_mem_write", bus.mem_write, 0);
        chk("reset_dma_active", bus.dma_active, 0);
        step();
        bus.cpu_write = 1'b0;
        rst_in = 1'b0;
        cpu_op("reset_reg", 1'b0, 16'hFF46, 8'h00, rd, mw, c);
        chk("reset_src_hi", rd, 8'h00);

        // Idle pass-through.
        cpu_op("idle_wr", 1'b1, 16'hC000, 8'h3C, rd, mw, c);
        chk("idle_write_forwarded", mw, 1);
        cpu_op("idle_rd", 1'b0, 16'hC000, 8'h00, rd, mw, c);
        chk("idle_read_back", rd, 8'h3C);
        mem['hC000] = 8'h00;
        bus.cpu_addr = 16'hC010;
        bus.cpu_wdata = 8'h11;
        bus.cpu_write = 1'b1;
        #2;
        chk("write_outside_mclk", bus.mem_write, 0);
        bus.cpu_write = 1'b0;
        bus.cpu_addr = 16'h0000;

        xfer("basic_c1", 8'hC1, -1, 8'h00, 1'b1, 1'b1);
        cpu_op("blocked_chk", 1'b0, 16'hC000, 8'h00, rd, mw, c);
        chk("blocked_write_dropped", rd, 8'h00);

        xfer("echo_e2", 8'hE2, -1, 8'h00, 1'b0, 1'b0);
        xfer("restart_d0", 8'hC5, 50, 8'hD0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            s1 = (r % 2 == 1) ? 8'(8'hE0 + $urandom_range(0, 31)) : 8'(8'hC0 + $urandom_range(0, 31));
            k  = (r == 3) ? int'($urandom_range(0, LEN - 1)) : -1;
            xfer($sformatf("rand%0d", r), s1, k, s1 ^ 8'h08, 1'b0, 1'b0);
        end

        // Reset in the middle of a transfer, asserted in an RD cycle so the following WR is suppressed.
        fill_src(8'hC3, 1'b0);
        base = wr_oam;
        cpu_op("rst80_start", 1'b1, 16'hFF46, 8'hC3, rd, mw, c);
        wait_wr(base + 80);
        do step(); while (!mclk_in);
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        #2;
        chk("rst80_mem_write", bus.mem_write, 0);
        chk("rst80_dma_active", bus.dma_active, 0);
        repeat (40) step();
        chk("rst80_no_more_writes", wr_oam - base, 80);
        cpu_op("rst80_reg", 1'b0, 16'hFF46, 8'h00, rd, mw, c);
        chk("rst80_src_hi", rd, 8'h00);

        // Reset beats a simultaneous start write.
        do step(); while (!mclk_in);
        rst_in = 1'b1;
        bus.cpu_addr = 16'hFF46;
        bus.cpu_wdata = 8'h77;
        bus.cpu_write = 1'b1;
        #2;
        chk("rstprio_mem_write", bus.mem_write, 0);
        step();
        rst_in = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr = 16'h0000;
        #2;
        chk("rstprio_dma_active", bus.dma_active, 0);
        base = wr_oam;
        repeat (20) step();
        chk("rstprio_no_writes", wr_oam - base, 0);
        cpu_op("rstprio_reg", 1'b0, 16'hFF46, 8'h00, rd, mw, c);
        chk("rstprio_src_hi", rd, 8'h00);

        xfer("after_reset", 8'hDF, -1, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_LEN, default 160, number of bytes copied per transfer.
REQ-002 Parameter OAM_BASE, default 16'hFE00, first destination address.
REQ-003 Parameter DMA_REG_ADDR, default 16'hFF46, address of the DMA source/start register.
REQ-004 One clock; reset is synchronous and active-high; ports clk_in and rst_in.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 mclk_in  input  1  M-cycle strobe, one clk_in cycle high per M-cycle, period fixed at 4 clk_in cycles.
REQ-008 cpu_addr  input  16  CPU address.
REQ-009 cpu_wdata  input  8  CPU write data.
REQ-010 cpu_write  input  1  CPU write request, committed in the mclk_in-high cycle.
REQ-011 cpu_rdata  output  8  read data returned to the CPU.
REQ-012 addr_bus  output  16  address to mem_map.
REQ-013 mem_in  input  8  read data from mem_map, combinational on addr_bus.
REQ-014 mem_out  output  8  write data to mem_map.
REQ-015 mem_write  output  1  write strobe to mem_map.
REQ-016 dma_active  output  1  high while a transfer is pending or in progress.

Function
REQ-017 States: IDLE, DELAY, RD, WR, WAIT.
REQ-018 A CPU write to DMA_REG_ADDR in an mclk_in-high cycle SHALL load src_hi and enter DELAY next cycle; it is not forwarded (mem_write=0).
REQ-019 A CPU read of DMA_REG_ADDR SHALL return src_hi.
REQ-020 src_hi values 8'hE0-8'hFF SHALL be masked to 8'hC0-8'hDF (bit 5 cleared) for source addressing; readback returns the unmasked value.
REQ-021 DELAY SHALL last until the next mclk_in pulse; the first byte transfers after the following pulse, i.e. byte i transfers after pulse i+2, with the write pulse counted as pulse 0.
REQ-022 RD: the first cycle after a transfer pulse; addr_bus={src_hi_masked,idx}; mem_in latched.
REQ-023 WR: the next cycle; addr_bus=OAM_BASE+idx, mem_out=latched byte, mem_write=1; idx increments.
REQ-024 WAIT: holds until the next mclk_in pulse; returns to RD, or to IDLE when idx==DMA_LEN.
REQ-025 idx is 8 bits and SHALL never exceed DMA_LEN.
REQ-026 dma_active SHALL be high from the cycle after the start write until the cycle after the final WR.
REQ-027 All non-RD/WR cycles SHALL pass the CPU through: addr_bus=cpu_addr, mem_out=cpu_wdata, mem_write=cpu_write&&mclk_in, cpu_rdata=mem_in.
REQ-028 While dma_active, CPU addresses 16'hFF80-16'hFFFE and DMA_REG_ADDR SHALL behave normally.
REQ-029 While dma_active, any other CPU write SHALL be dropped (mem_write=0).
REQ-030 While dma_active, any other CPU read SHALL return per REQ-036/037.
REQ-031 A start write while dma_active SHALL restart: idx=0, new src_hi, DELAY; no write to the aborted byte after the restart cycle.

Reset
REQ-032 rst_in SHALL force IDLE, idx=0, src_hi=8'h00, latch=8'h00, dma_active=0, and mem_write=0.
REQ-033 rst_in SHALL abort any transfer in progress the same cycle; no further OAM writes occur.
REQ-034 rst_in SHALL take priority over a simultaneous start write.

Configuration
REQ-035 The macro OAM_DMA_BUS_CONFLICT_EN SHALL select the blocked-read value.
REQ-036 With OAM_DMA_BUS_CONFLICT_EN defined, a blocked CPU read SHALL return the last byte latched in RD.
REQ-037 Without OAM_DMA_BUS_CONFLICT_EN, a blocked CPU read SHALL return 8'hFF.

Verification
REQ-038 Write 8'hC1 to FF46, memory C100-C19F = i -> FE00+i = i, exactly 160 mem_write pulses, dma_active high for 161 M-cycles.
REQ-039 During DMA, CPU writes 8'h55 to FF90 then reads it back -> returns 8'h55; CPU write to C000 -> no mem_write.
REQ-040 During DMA, CPU reads 8000 -> 8'hFF without macro; with macro -> byte currently being copied.
REQ-041 Write 8'hE2 -> source E200 masked to C200; FF46 reads 8'hE2.
REQ-042 Restart with 8'hD0 at idx=50 -> remainder plus full 160 bytes copied from D000.
REQ-043 rst_in at idx=80 -> mem_write low next cycle, dma_active 0, FF46 reads 8'h00.
